string_hw_sequencer: RTL and testbench

STRING_HW_SEQUENCER -- requirements
Module: string_hw_sequencer

---
 rtl/string_hw_sequencer_if.sv | 39 +++
 rtl/string_hw_sequencer.sv | 153 +++++++++++++++
 tb/tb_string_hw_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/string_hw_sequencer_if.sv
// Command, operand, result and accelerator-bus signals of the string sequencer.
// slave = sequencer side, master = host/accelerator side.
interface string_hw_sequencer_if #(
    parameter int ADDRESS_BITS = 4
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [3:0]              cmd_index;
    logic [7:0]              cmd_length;
    logic                    src_valid;
    logic                    src_ready;
    logic [31:0]             src_data;
    logic                    res_valid;
    logic                    res_ready;
    logic [31:0]             res_data;
    logic                    m_chipselect;
    logic                    m_read;
    logic                    m_write;
    logic [ADDRESS_BITS:0]   m_address;
    logic [31:0]             m_writedata;
    logic [31:0]             m_readdata;
    logic                    busy;
    logic                    op_done;
    logic                    op_error;

    modport slave (
        input  cmd_valid, cmd_index, cmd_length, src_valid, src_data,
               res_ready, m_readdata,
        output cmd_ready, src_ready, res_valid, res_data, m_chipselect,
               m_read, m_write, m_address, m_writedata, busy, op_done, op_error
    );

    modport master (
        output cmd_valid, cmd_index, cmd_length, src_valid, src_data,
               res_ready, m_readdata,
        input  cmd_ready, src_ready, res_valid, res_data, m_chipselect,
               m_read, m_write, m_address, m_writedata, busy, op_done, op_error
    );
endinterface

// File: rtl/string_hw_sequencer.sv
// Drives a string accelerator: loads A/B operands, starts it, polls done, streams results out.
// Operand writes issue in the accept cycle; result words hold under res_ready low; polls abort after POLL_LIMIT.
module string_hw_sequencer #(
    parameter int MAX_BLOCKS   = 2,
    parameter int ADDRESS_BITS = 4,
    parameter int POLL_LIMIT   = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    string_hw_sequencer_if.slave bus
);
    localparam int NWORDS = 2 * MAX_BLOCKS;
    localparam int CW     = $clog2(NWORDS) + 1;
    localparam int PW     = $clog2(POLL_LIMIT) + 1;
    localparam int AW     = ADDRESS_BITS + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_GO, S_POLL_RD, S_POLL_WT,
        S_RES_RD, S_RES_WT, S_RES_OUT, S_CLEAR, S_FIN
    } state_t;

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_poll;
    logic [3:0]  r_index;
    logic [7:0]  r_length;
    logic        r_err;
    logic [31:0] r_res_data;

    logic [AW-1:0] w_cnt_addr;
    logic [31:0]   w_ctrl;
    logic          w_read;
    logic          w_write;
    logic [AW-1:0] w_address;
    logic [31:0]   w_writedata;

    // Word counter doubles as the register offset: data registers start at address 1.
    assign w_cnt_addr = AW'(r_cnt) + AW'(1);
    assign w_ctrl     = {18'b0, r_length, r_index, 1'b1, 1'b0};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_poll     <= '0;
            r_index    <= '0;
            r_length   <= '0;
            r_err      <= 1'b0;
            r_res_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_index  <= bus.cmd_index;
                        r_length <= bus.cmd_length;
                        r_cnt    <= '0;
                        r_poll   <= '0;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.src_valid) begin
                        if (r_cnt == CW'(NWORDS - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_GO;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_GO:      r_state <= S_POLL_RD;
                S_POLL_RD: r_state <= S_POLL_WT;
                S_POLL_WT: begin
                    if (bus.m_readdata[0]) begin
                        r_cnt   <= '0;
                        r_state <= S_RES_RD;
                    end else if (r_poll < PW'(POLL_LIMIT - 1)) begin
                        r_poll  <= r_poll + PW'(1);
                        r_state <= S_POLL_RD;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= S_CLEAR;
                    end
                end
                S_RES_RD:  r_state <= S_RES_WT;
                S_RES_WT: begin
                    r_res_data <= bus.m_readdata;
                    r_state    <= S_RES_OUT;
                end
                S_RES_OUT: begin
                    if (bus.res_ready) begin
                        if (r_cnt == CW'(MAX_BLOCKS - 1)) begin
                            r_state <= S_CLEAR;
                        end else begin
                            r_cnt   <= r_cnt + CW'(1);
                            r_state <= S_RES_RD;
                        end
                    end
                end
                S_CLEAR:   r_state <= S_FIN;
                S_FIN: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // Bus strobes decode from the state register so an accept in LOAD writes the same cycle.
    always_comb begin
        w_read      = 1'b0;
        w_write     = 1'b0;
        w_address   = '0;
        w_writedata = '0;
        case (r_state)
            S_LOAD: begin
                if (bus.src_valid) begin
                    w_write     = 1'b1;
                    w_address   = w_cnt_addr;
                    w_writedata = bus.src_data;
                end
            end
            S_GO: begin
                w_write     = 1'b1;
                w_writedata = w_ctrl;
            end
            S_POLL_RD: w_read = 1'b1;
            S_RES_RD: begin
                w_read    = 1'b1;
                w_address = w_cnt_addr;
            end
            S_CLEAR:   w_write = 1'b1;
            default: begin
                w_read  = 1'b0;
                w_write = 1'b0;
            end
        endcase
    end

    assign bus.cmd_ready    = (r_state == S_IDLE);
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.src_ready    = (r_state == S_LOAD);
    assign bus.res_valid    = (r_state == S_RES_OUT);
    assign bus.res_data     = r_res_data;
    assign bus.m_read       = w_read;
    assign bus.m_write      = w_write;
    assign bus.m_chipselect = w_read | w_write;
    assign bus.m_address    = w_address;
    assign bus.m_writedata  = w_writedata;
    assign bus.op_done      = (r_state == S_FIN) && !r_err;
    assign bus.op_error     = (r_state == S_FIN) && r_err;
endmodule

// File: tb/tb_string_hw_sequencer.sv
// Randomized scoreboard bench: expected bus/result events queued per command, popped by a monitor.
module tb_string_hw_sequencer;
    localparam int MB = 2;
    localparam int AB = 4;
    localparam int PL = 4;
    localparam int NW = 2 * MB;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    string_hw_sequencer_if #(.ADDRESS_BITS(AB)) sq();

    string_hw_sequencer #(
        .MAX_BLOCKS(MB), .ADDRESS_BITS(AB), .POLL_LIMIT(PL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sq)
    );

    // kind: 0 write, 1 read, 2 result word, 3 op_done, 4 op_error
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          done_at = 0;
    logic [31:0] res_words[MB];
    int          res_mode = 0;
    int          op_id = 0;
    int          polls = 0;
    bit          stalled = 1'b0;
    logic [31:0] stall_data = '0;
    logic [31:0] wv[NW];
    logic [31:0] rv[MB];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accelerator: done reported from the done_at-th poll on, read data one cycle late.
    always @(posedge clk) begin
        if (sq.m_write && sq.m_address == 0 && sq.m_writedata[1])
            polls = 0;
        if (sq.m_read) begin
            if (sq.m_address == 0) begin
                polls = polls + 1;
                sq.m_readdata <= {31'b0, (done_at != 0 && polls >= done_at)};
            end else if (sq.m_address >= 1 && sq.m_address <= MB) begin
                sq.m_readdata <= res_words[int'(sq.m_address) - 1];
            end else begin
                sq.m_readdata <= $urandom;
            end
        end else begin
            sq.m_readdata <= $urandom;
        end
    end

    task automatic expect_ev(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event got kind=%0d addr=%0h data=%08h required none", kind, addr, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.addr != addr || e.data != data) begin
                failures++;
                $display("FAIL event got kind=%0d addr=%0h data=%08h required kind=%0d addr=%0h data=%08h",
                         kind, addr, data, e.kind, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        checks++;
        if ((sq.m_read && sq.m_write) || (sq.op_done && sq.op_error) ||
            (sq.m_chipselect != (sq.m_read | sq.m_write))) begin
            failures++;
            $display("FAIL protocol got rd=%b wr=%b cs=%b done=%b err=%b required exclusive strobes",
                     sq.m_read, sq.m_write, sq.m_chipselect, sq.op_done, sq.op_error);
        end
        if (stalled) begin
            checks++;
            if (!sq.res_valid || sq.res_data != stall_data) begin
                failures++;
                $display("FAIL res_stable got valid=%b data=%08h required valid=1 data=%08h",
                         sq.res_valid, sq.res_data, stall_data);
            end
        end
        stalled    = sq.res_valid && !sq.res_ready && reset;
        stall_data = sq.res_data;
        if (sq.m_write) expect_ev(0, 32'(sq.m_address), sq.m_writedata);
        if (sq.m_read) expect_ev(1, 32'(sq.m_address), 32'h0);
        if (sq.res_valid && sq.res_ready) expect_ev(2, 32'h0, sq.res_data);
        if (sq.op_done) expect_ev(3, 32'h0, 32'h0);
        if (sq.op_error) expect_ev(4, 32'h0, 32'h0);
    end

    initial begin
        int sc;
        int seen_id;
        sc = 0;
        seen_id = 0;
        sq.res_ready = 1'b0;
        forever begin
            step();
            if (op_id != seen_id) begin
                sc = 0;
                seen_id = op_id;
            end
            case (res_mode)
                0: sq.res_ready = 1'b1;
                1: sq.res_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (sq.res_valid && sc < 5) begin
                        sq.res_ready = 1'b0;
                        sc++;
                    end else begin
                        sq.res_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic check_reset(input string nm);
        checks++;
        if ({sq.cmd_ready, sq.src_ready, sq.res_valid, sq.m_chipselect, sq.m_read, sq.m_write,
             sq.busy, sq.op_done, sq.op_error} !== 9'b100000000) begin
            failures++;
            $display("FAIL %s_flags got %b%b%b%b%b%b%b%b%b required 100000000", nm,
                     sq.cmd_ready, sq.src_ready, sq.res_valid, sq.m_chipselect, sq.m_read,
                     sq.m_write, sq.busy, sq.op_done, sq.op_error);
        end
        checks++;
        if (sq.m_address !== '0 || sq.m_writedata !== 32'h0 || sq.res_data !== 32'h0) begin
            failures++;
            $display("FAIL %s_data got addr=%0h wdata=%08h res=%08h required all zero", nm,
                     sq.m_address, sq.m_writedata, sq.res_data);
        end
    endtask

    task automatic run_op(input logic [3:0] idx, input logic [7:0] len, input int dn,
                          input bit srnd, input int rmode, input bit bpulse, input int abort_after);
        bit ok, v, rdy, got, pulsed;
        int npoll, i, guard;
        done_at   = dn;
        res_words = rv;
        res_mode  = rmode;
        op_id++;
        ok    = (dn >= 1 && dn <= PL);
        npoll = ok ? dn : PL;
        for (int k = 0; k < NW; k++) exp_q.push_back('{0, 32'(k + 1), wv[k]});
        exp_q.push_back('{0, 32'h0, {18'b0, len, idx, 2'b10}});
        repeat (npoll) exp_q.push_back('{1, 32'h0, 32'h0});
        if (ok) begin
            for (int k = 0; k < MB; k++) begin
                exp_q.push_back('{1, 32'(k + 1), 32'h0});
                exp_q.push_back('{2, 32'h0, rv[k]});
            end
        end
        exp_q.push_back('{0, 32'h0, 32'h0});
        exp_q.push_back('{ok ? 3 : 4, 32'h0, 32'h0});

        sq.cmd_valid  = 1'b1;
        sq.cmd_index  = idx;
        sq.cmd_length = len;
        got = 1'b0;
        for (guard = 0; guard < 50 && !got; guard++) begin
            @(negedge clk);
            rdy = sq.cmd_ready;
            step();
            got = rdy;
        end
        sq.cmd_valid  = 1'b0;
        sq.cmd_index  = 4'($urandom);
        sq.cmd_length = 8'($urandom);
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL cmd_accept got no cmd_ready required accept within 50 cycles");
            return;
        end

        i = 0;
        guard = 0;
        while (i < NW && i != abort_after && guard < 500) begin
            v = srnd ? 1'($urandom_range(0, 1)) : 1'b1;
            sq.src_valid = v;
            sq.src_data  = v ? wv[i] : $urandom;
            @(negedge clk);
            rdy = sq.src_ready;
            step();
            if (v && rdy) i++;
            guard++;
        end
        sq.src_valid = 1'b0;
        if (i < NW && i != abort_after) begin
            checks++;
            failures++;
            $display("FAIL src_load got %0d words required %0d", i, NW);
        end

        if (abort_after >= 0) begin
            reset = 1'b0;
            exp_q.delete();
            #1;
            check_reset("reset_async");
            step();
            step();
            check_reset("reset_hold");
            reset = 1'b1;
            step();
            return;
        end

        got = 1'b0;
        pulsed = 1'b0;
        for (guard = 0; guard < 3000 && !got; guard++) begin
            @(negedge clk);
            if (sq.op_done || sq.op_error) begin
                got = 1'b1;
                checks++;
                if (sq.cmd_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL fin_cmd_ready got %b required 0", sq.cmd_ready);
                end
            end else if (bpulse && !pulsed && sq.m_read && sq.m_address == 0) begin
                step();
                sq.cmd_valid  = 1'b1;
                sq.cmd_index  = 4'hF;
                sq.cmd_length = 8'hFF;
                @(negedge clk);
                checks++;
                if (sq.cmd_ready !== 1'b0 || sq.busy !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_cmd got ready=%b busy=%b required ready=0 busy=1",
                             sq.cmd_ready, sq.busy);
                end
                pulsed = 1'b1;
                step();
                sq.cmd_valid = 1'b0;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL op_finish got no done/error required pulse within 3000 cycles");
        end
        step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_events got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic rand_data();
        for (int k = 0; k < NW; k++) wv[k] = $urandom;
        for (int k = 0; k < MB; k++) rv[k] = $urandom;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sq.cmd_valid  = 1'b0;
        sq.cmd_index  = '0;
        sq.cmd_length = '0;
        sq.src_valid  = 1'b0;
        sq.src_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_init");
        reset = 1'b1;
        step();

        wv[0] = 32'h61626364; wv[1] = 32'h65666768;
        wv[2] = 32'h41424344; wv[3] = 32'h45464748;
        rv[0] = 32'hAAAA0001; rv[1] = 32'hAAAA0002;
        run_op(4'd3, 8'd5, 3, 1'b0, 0, 1'b0, -1);

        rand_data();
        run_op(4'($urandom), 8'($urandom), 2, 1'b1, 2, 1'b0, -1);

        rand_data();
        run_op(4'($urandom), 8'($urandom), 0, 1'b0, 0, 1'b0, -1);

        rand_data();
        run_op(4'($urandom), 8'($urandom), 4, 1'b0, 0, 1'b1, -1);

        rand_data();
        run_op(4'($urandom), 8'($urandom), 2, 1'b0, 0, 1'b0, 2);
        rand_data();
        run_op(4'($urandom), 8'($urandom), 1, 1'b1, 0, 1'b0, -1);

        for (int n = 0; n < 20; n++) begin
            rand_data();
            run_op(4'($urandom), 8'($urandom), $urandom_range(0, 6), 1'b1,
                   $urandom_range(1, 2), 1'($urandom_range(0, 1)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
